// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from active-low hsync/vsync edges and checks
// line/frame periods, reporting lock state and a saturating violation count.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       locked,
    output logic       frame_start,
    output logic       line_err,
    output logic [7:0] err_cnt
);

    localparam logic [9:0]  HT_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HSS       = 10'(H_SYNC_START);
    localparam logic [9:0]  HA        = 10'(H_ACTIVE);
    localparam logic [9:0]  VT_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VT        = 10'(V_TOTAL);
    localparam logic [9:0]  VSS       = 10'(V_SYNC_START);
    localparam logic [9:0]  VA        = 10'(V_ACTIVE);
    localparam logic [10:0] HT11      = 11'(H_TOTAL);
    localparam logic [10:0] TMO_LAST  = 11'(2 * H_TOTAL - 1);
    localparam logic [7:0]  GOOD_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      r_state;
    logic        r_hs_prev, r_vs_prev, r_h_seen, r_frame_bad;
    logic [10:0] r_hlen;
    logic [9:0]  r_vlen;
    logic [7:0]  r_good;
    logic [9:0]  r_h_cnt, r_v_cnt;
    logic        r_valid, r_locked, r_frame_start, r_line_err;
    logic [7:0]  r_err_cnt;

    logic       w_hfall, w_vfall, w_hwrap, w_timeout;
    logic       w_bad_line, w_bad_frame, w_bad, w_good_frame;
    logic       w_viol, w_lock_next;
    logic [9:0] w_h_next, w_v_next;

    always_comb begin
        w_hfall = ~hsync & r_hs_prev;
        w_vfall = ~vsync & r_vs_prev;
        w_hwrap = ~w_hfall & (r_h_cnt == HT_LAST);
        if (w_hfall)      w_h_next = HSS;
        else if (w_hwrap) w_h_next = '0;
        else              w_h_next = r_h_cnt + 10'd1;
        if (w_vfall)      w_v_next = VSS;
        else if (w_hwrap) w_v_next = (r_v_cnt == VT_LAST) ? '0 : r_v_cnt + 10'd1;
        else              w_v_next = r_v_cnt;
        w_timeout    = ~w_hfall & (r_hlen == TMO_LAST);
        w_bad_line   = w_hfall & r_h_seen & (r_hlen != HT11);
        w_bad_frame  = w_vfall & (r_vlen != VT);
        w_bad        = w_bad_line | w_bad_frame;
        // A frame holding an already-reported bad line is not good, but is not reported again
        w_good_frame = w_vfall & ~w_bad & ~r_frame_bad;
        w_viol       = (r_state != SEARCH) & (w_timeout | w_bad);
        w_lock_next  = ~w_timeout & ~w_bad &
                       ((r_state == LOCKED) |
                        ((r_state == ACQUIRE) & w_good_frame & (r_good == GOOD_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= SEARCH;
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_h_seen      <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_hlen        <= '0;
            r_vlen        <= '0;
            r_good        <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            if (pix_en) begin
                r_hs_prev <= hsync;
                r_vs_prev <= vsync;
                r_h_cnt   <= w_h_next;
                r_v_cnt   <= w_v_next;
                r_hlen    <= w_hfall ? 11'd1 : ((r_hlen == 11'h7FF) ? r_hlen : r_hlen + 11'd1);
                if (w_vfall)
                    r_vlen <= {9'd0, w_hfall};
                else if (w_hfall && (r_vlen != '1))
                    r_vlen <= r_vlen + 10'd1;
                if (w_vfall)
                    r_frame_bad <= 1'b0;
                else if (w_bad_line)
                    r_frame_bad <= 1'b1;
                r_line_err <= w_viol;
                if (w_viol && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + 8'd1;
                r_locked      <= w_lock_next;
                r_valid       <= w_lock_next & (w_h_next < HA) & (w_v_next < VA);
                r_frame_start <= (r_state == LOCKED) & (w_h_next == '0) & (w_v_next == '0);
                if (w_timeout) begin
                    r_state  <= SEARCH;
                    r_h_seen <= 1'b0;
                end else begin
                    if (w_hfall)
                        r_h_seen <= 1'b1;
                    case (r_state)
                        SEARCH: if (w_vfall) begin
                            r_state <= ACQUIRE;
                            r_good  <= '0;
                        end
                        ACQUIRE: if (w_bad) begin
                            r_good <= '0;
                        end else if (w_good_frame) begin
                            if (r_good == GOOD_LAST)
                                r_state <= LOCKED;
                            else
                                r_good <= r_good + 8'd1;
                        end
                        LOCKED: if (w_bad) begin
                            r_state <= ACQUIRE;
                            r_good  <= '0;
                        end
                        default: r_state <= SEARCH;
                    endcase
                end
            end
        end
    end

    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign valid       = r_valid;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign line_err    = r_line_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: reduced-size timing, per-clock scoreboard against a
// behavioural model, plus a phase table with hand-derived end-of-phase results.
module tb_vga_sync_decoder;

    localparam int HT  = 32;
    localparam int HA  = 24;
    localparam int HSS = 26;
    localparam int HSW = 4;
    localparam int VT  = 16;
    localparam int VA  = 12;
    localparam int VSS = 13;
    localparam int VSW = 2;
    localparam int LF  = 2;

    localparam int S_SEARCH = 0, S_ACQ = 1, S_LOCK = 2;
    localparam int K_NOM = 0, K_SLINE = 1, K_SFRAME = 2, K_TMO = 3, K_SAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] h_cnt, v_cnt;
    logic       valid, locked, frame_start, line_err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .locked(locked),
        .frame_start(frame_start), .line_err(line_err), .err_cnt(err_cnt)
    );

    typedef struct {
        int hc; int vc; int err;
        bit valid; bit locked; bit fs; bit le;
    } exp_t;

    typedef struct {
        int kind; int frames; int div; int exp_locked; int exp_err; int exp_pulses;
    } phase_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int g_fs, g_val, g_le;

    int m_hc, m_vc, m_hlen, m_vlen, m_good, m_err, m_st;
    bit m_hsp, m_vsp, m_seen, m_fbad;
    exp_t m_out;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_hlen = 0; m_vlen = 0; m_good = 0; m_err = 0;
        m_st = S_SEARCH; m_hsp = 1'b1; m_vsp = 1'b1; m_seen = 1'b0; m_fbad = 1'b0;
        m_out.hc = 0; m_out.vc = 0; m_out.err = 0;
        m_out.valid = 1'b0; m_out.locked = 1'b0; m_out.fs = 1'b0; m_out.le = 1'b0;
    endtask

    task automatic model_step(input bit pe, input bit hs, input bit vs);
        bit hf, vf, wrap, bl, bf, gf, tmo, viol;
        int st0;
        m_out.fs = 1'b0;
        m_out.le = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!pe) return;
        st0 = m_st;
        hf = !hs && m_hsp;
        vf = !vs && m_vsp;
        m_hsp = hs;
        m_vsp = vs;
        bl   = hf && m_seen && (m_hlen != HT);
        bf   = vf && (m_vlen != VT);
        gf   = vf && !bf && !bl && !m_fbad;
        tmo  = !hf && (m_hlen + 1 == 2 * HT);
        wrap = !hf && (m_hc == HT - 1);
        m_hc = hf ? HSS : (wrap ? 0 : m_hc + 1);
        if (vf) m_vc = VSS;
        else if (wrap) m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
        m_hlen = hf ? 1 : ((m_hlen < 2047) ? m_hlen + 1 : 2047);
        if (vf) m_vlen = int'(hf);
        else if (hf && m_vlen < 1023) m_vlen++;
        if (vf) m_fbad = 1'b0;
        else if (bl) m_fbad = 1'b1;
        if (hf) m_seen = 1'b1;
        viol = 1'b0;
        if (tmo) begin
            viol = (st0 != S_SEARCH);
            m_st = S_SEARCH;
            m_seen = 1'b0;
        end else if (st0 == S_SEARCH) begin
            if (vf) begin m_st = S_ACQ; m_good = 0; end
        end else if (bl || bf) begin
            viol = 1'b1; m_st = S_ACQ; m_good = 0;
        end else if (st0 == S_ACQ && gf) begin
            m_good++;
            if (m_good == LF) m_st = S_LOCK;
        end
        if (viol) begin
            m_out.le = 1'b1;
            if (m_err < 255) m_err++;
        end
        m_out.hc = m_hc;
        m_out.vc = m_vc;
        m_out.err = m_err;
        m_out.locked = (m_st == S_LOCK);
        m_out.valid = m_out.locked && (m_hc < HA) && (m_vc < VA);
        m_out.fs = (st0 == S_LOCK) && (m_hc == 0) && (m_vc == 0);
    endtask

    // One clk: drive at negedge, queue the expectation, compare 1 ns after posedge.
    task automatic cyc(input bit pe, input bit hs, input bit vs);
        exp_t e;
        @(negedge clk);
        pix_en = pe; hsync = hs; vsync = vs;
        model_step(pe, hs, vs);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("h_cnt", int'(h_cnt), e.hc);
        chk("v_cnt", int'(v_cnt), e.vc);
        chk("err_cnt", int'(err_cnt), e.err);
        chk("valid", int'(valid), int'(e.valid));
        chk("locked", int'(locked), int'(e.locked));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("line_err", int'(line_err), int'(e.le));
        g_le += int'(line_err);
    endtask

    task automatic run_line(input int div, input int l, input int len, input bit mask, input bit cg);
        bit hs, vs;
        for (int p = 0; p < len; p++) begin
            hs = mask ? 1'b1 : !(p >= HSS && p < HSS + HSW);
            vs = !(l >= VSS && l < VSS + VSW);
            cyc(1'b1, hs, vs);
            if (cg) begin
                chk("gen_h", int'(h_cnt), p);
                chk("gen_v", int'(v_cnt), l);
                chk("gen_valid", int'(valid), int'(p < HA && l < VA));
                g_fs  += int'(frame_start);
                g_val += int'(valid);
            end
            for (int c = 1; c < div; c++) cyc(1'b0, hs, vs);
        end
    endtask

    task automatic run_phase(input int idx, input phase_t p);
        int nl, len;
        bit mask, cg;
        g_fs = 0; g_val = 0; g_le = 0;
        for (int f = 0; f < p.frames; f++) begin
            nl = (p.kind == K_SFRAME && f == 0) ? VT - 1 : VT;
            for (int l = 0; l < nl; l++) begin
                len  = (p.kind == K_SAT || (p.kind == K_SLINE && f == 0 && l == 5)) ? HT - 1 : HT;
                mask = (p.kind == K_TMO && f == 0 && (l == 3 || l == 4));
                cg   = (p.kind == K_NOM && f == p.frames - 1);
                run_line(p.div, l, len, mask, cg);
            end
        end
        chk($sformatf("phase%0d_locked", idx), int'(locked), p.exp_locked);
        chk($sformatf("phase%0d_err_cnt", idx), int'(err_cnt), p.exp_err);
        if (p.exp_pulses >= 0)
            chk($sformatf("phase%0d_line_err_pulses", idx), g_le, p.exp_pulses);
        if (p.kind == K_NOM) begin
            chk($sformatf("phase%0d_frame_start_count", idx), g_fs, 1);
            chk($sformatf("phase%0d_valid_samples", idx), g_val, HA * VA);
        end
    endtask

    phase_t ph[6];

    initial begin
        ph[0] = '{K_NOM,    4, 4, 1, 0,   0};
        ph[1] = '{K_SLINE,  3, 4, 1, 1,   1};
        ph[2] = '{K_SFRAME, 4, 4, 1, 2,   1};
        ph[3] = '{K_TMO,    3, 2, 1, 3,   1};
        ph[4] = '{K_SAT,   19, 1, 0, 255, -1};
        ph[5] = '{K_NOM,    4, 4, 1, 255, 1};

        model_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_phase(i, ph[i]);

        // Asynchronous reset mid-frame while locked, then relock from mid-frame.
        for (int l = 0; l < 7; l++) run_line(4, l, HT, 1'b0, 1'b0);
        chk("locked_before_rst", int'(locked), 1);
        rst = 1'b1;
        #1;
        chk("rst_h_cnt", int'(h_cnt), 0);
        chk("rst_v_cnt", int'(v_cnt), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_line_err", int'(line_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        model_reset();
        repeat (3) cyc(1'b0, hsync, vsync);
        rst = 1'b0;
        for (int l = 7; l < VT; l++) run_line(4, l, HT, 1'b0, 1'b0);
        for (int l = 0; l < VT; l++) run_line(4, l, HT, 1'b0, 1'b0);
        for (int l = 0; l < VSS; l++) run_line(4, l, HT, 1'b0, 1'b0);
        chk("locked_before_3rd_vfall", int'(locked), 0);
        run_line(4, VSS, HT, 1'b0, 1'b0);
        chk("locked_after_3rd_vfall", int'(locked), 1);
        chk("err_cnt_after_relock", int'(err_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
